// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword bit positions, receiver FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Position of each parity/data bit inside the codeword c[6:0].
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D0_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int D1_IDX = 4;
    localparam int D2_IDX = 5;
    localparam int D3_IDX = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/hamming74_correct.sv
// Hamming(7,4) single-error corrector: syndrome, bit fix-up and data extraction.
// Latency: purely combinational.
// Backpressure: none; a pure function of the code input.
//
// Ports:
//   code      - received 7-bit codeword c[6:0]
//   data      - corrected nibble {d3,d2,d1,d0}
//   syndrome  - {p4,p2,p1}; nonzero value S names flipped bit c[S-1]
//   corrected - high when a bit was flipped (double errors are miscorrected)
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic [SYN_W-1:0]  syndrome,
    output logic              corrected
);

    logic [CODE_W-1:0] fixed;

    always_comb begin
        syndrome[0] = code[P1_IDX] ^ code[D0_IDX] ^ code[D1_IDX] ^ code[D3_IDX];
        syndrome[1] = code[P2_IDX] ^ code[D0_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
        syndrome[2] = code[P4_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
        corrected   = (syndrome != '0);

        // Syndrome value S points at position S-1; zero matches no position.
        fixed = code;
        for (int i = 0; i < CODE_W; i++) begin
            fixed[i] = code[i] ^ (syndrome == SYN_W'(i + 1));
        end

        data = {fixed[D3_IDX], fixed[D2_IDX], fixed[D1_IDX], fixed[D0_IDX]};
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// Bit-serial Hamming(7,4) receiver: deserialise LSB-first codewords, correct, emit nibble.
// Latency: outputs valid the cycle after bit c6 is accepted.
// Backpressure: single-entry output register; a word completing while it is full and not consumed is dropped (overflow).
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   rx_bit, rx_bit_valid, rx_sof     - serial input; rx_sof marks c0 of a new word
//   out_data/out_syndrome/out_corrected/out_valid, out_ready - decoded word handshake
//   framing_err, overflow            - one-cycle status pulses
//   corr_count, drop_count           - saturating link-health counters
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_bit,
    input  logic              rx_bit_valid,
    input  logic              rx_sof,
    output logic [DATA_W-1:0] out_data,
    output logic [SYN_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              framing_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  drop_count
);

    rx_state_e         state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;
    logic              word_done;
    logic              frame_abort;

    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  dec_syn;
    logic              dec_corr;
    logic              load;
    logic              drop;

    logic [DATA_W-1:0] data_q;
    logic [SYN_W-1:0]  syn_q;
    logic              corr_q;
    logic              valid_q;
    logic              framing_err_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        if (rx_bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    // Stray bits without a start marker are ignored.
                    if (rx_sof) begin
                        shreg_d         = '0;
                        shreg_d[P1_IDX] = rx_bit;
                        idx_d           = 3'd1;
                        state_d         = SHIFT;
                    end
                end
                SHIFT: begin
                    if (rx_sof) begin
                        // Restart: partial word is thrown away, this bit is the new c0.
                        frame_abort     = 1'b1;
                        shreg_d         = '0;
                        shreg_d[P1_IDX] = rx_bit;
                        idx_d           = 3'd1;
                    end else begin
                        shreg_d[idx_q] = rx_bit;
                        if (idx_q == 3'(D3_IDX)) begin
                            word_done = 1'b1;
                            idx_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Decoder sees the word including the c6 arriving this cycle.
    hamming74_correct u_correct (
        .code      (shreg_d),
        .data      (dec_data),
        .syndrome  (dec_syn),
        .corrected (dec_corr)
    );

    assign load = word_done && (!valid_q || out_ready);
    assign drop = word_done && valid_q && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q        <= '0;
            syn_q         <= '0;
            corr_q        <= 1'b0;
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
            corr_cnt_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            framing_err_q <= frame_abort;
            overflow_q    <= drop;
            if (load) begin
                data_q  <= dec_data;
                syn_q   <= dec_syn;
                corr_q  <= dec_corr;
                valid_q <= 1'b1;
                if (dec_corr && (corr_cnt_q != '1)) begin
                    corr_cnt_q <= corr_cnt_q + 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign out_data      = data_q;
    assign out_syndrome  = syn_q;
    assign out_corrected = corr_q;
    assign out_valid     = valid_q;
    assign framing_err   = framing_err_q;
    assign overflow      = overflow_q;
    assign corr_count    = corr_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: doc/hamming_serial_rx.md
Name: hamming_serial_rx

Overview:
Receive-side companion to the Hamming(7,4) encoder path. Accepts encoded codewords as a bit-serial stream, LSB (c0) first, and deserialises them into 7-bit codewords. Each codeword is decoded with single-error correction and the corrected 4-bit nibble is presented on a valid/ready output with status flags. Saturating counters track corrected words and dropped words for link-health monitoring.

Parameters:
CNT_W, 16, width of corr_count and drop_count (saturating)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
rx_bit  in  1  serial code bit
rx_bit_valid  in  1  rx_bit is sampled this cycle
rx_sof  in  1  qualifies rx_bit_valid; marks bit c0 of a new codeword
out_data  out  4  corrected nibble {d3,d2,d1,d0}
out_syndrome  out  3  syndrome {p4,p2,p1} of the emitted word
out_corrected  out  1  a single bit was flipped in this word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word when high with out_valid
framing_err  out  1  one-cycle pulse: codeword aborted by an early rx_sof
overflow  out  1  one-cycle pulse: completed word dropped because the output was full
corr_count  out  CNT_W  saturating count of corrected words emitted
drop_count  out  CNT_W  saturating count of overflow drops

Behaviour:
- Codeword bit mapping: c0=p1, c1=p2, c2=d0, c3=p4, c4=d1, c5=d2, c6=d3.
- Syndrome:
  - p1 = c0^c2^c4^c6
  - p2 = c1^c2^c5^c6
  - p4 = c3^c4^c5^c6
  - Nonzero syndrome S means bit c[S-1] is flipped before data extraction.
  - Data = {c6,c5,c4,c2}.
- Reset values: out_data=0, out_syndrome=0, out_corrected=0, out_valid=0, framing_err=0, overflow=0, both counters=0. FSM goes to IDLE, bit index = 0, shift register = 0.
- FSM states:
  - IDLE: bits with rx_bit_valid=1 and rx_sof=0 are ignored. rx_bit_valid=1 and rx_sof=1 stores c0, sets bit index=1, and moves to SHIFT.
  - SHIFT: each rx_bit_valid stores bit c[idx] and increments idx. When c6 is stored (idx was 6), the word is complete and the FSM returns to IDLE.
  - Cycles with rx_bit_valid=0 hold state with no timeout.
- Early start of frame: rx_sof with rx_bit_valid while in SHIFT and idx is 1..6:
  - The partial word is discarded and framing_err pulses.
  - The new bit is taken as c0 of a new word (idx=1, stay in SHIFT).
  - The pulse appears in the cycle after the offending bit.
- Latency and output register:
  - The bit c6 accepted in cycle N gives decoded outputs registered with out_valid=1 in cycle N+1.
  - Decode is combinational off the assembled word, feeding a single-entry output register.
- Handshake:
  - out_data, out_syndrome and out_corrected stay stable while out_valid=1 and out_ready=0.
  - The word is consumed on a cycle with out_valid and out_ready both high; out_valid drops next cycle unless a new word loads the register in that same cycle (back-to-back words allowed).
  - A completed word loads the register if it is empty or is being consumed this cycle.
  - Otherwise the new word is dropped, overflow pulses and drop_count increments; the held word is unaffected.
- Counters: corr_count increments when a word with out_corrected=1 is loaded into the output register. Both counters saturate at all-ones.
- Double-bit errors are miscorrected as single errors. This is documented behaviour; no detection is required.
- rst asserted mid-word or with out_valid=1 discards all state; no pulses are generated on reset.

Decomposition:
- Shared package hamming_pkg holds:
  - codeword width 7 and data width 4;
  - bit-position constants P1_IDX=0, P2_IDX=1, D0_IDX=2, P4_IDX=3, D1_IDX=4, D2_IDX=5, D3_IDX=6;
  - the FSM state typedef {IDLE, SHIFT}.
- One sub-module, hamming74_correct: combinational; input 7-bit code; outputs data[3:0], syndrome[2:0], corrected. It is reused by any future parallel receiver.

Test Plan:
- Clean word: send 7'h55 (data 4'b1011) LSB first, 1 bit/cycle, out_ready=1 -> out_valid=1 exactly 1 cycle after c6; out_data=4'hB, out_syndrome=0, out_corrected=0; corr_count stays 0.
- Single error: send 7'h45 (bit c4 flipped) -> out_data=4'hB, out_syndrome=3'b101, out_corrected=1, corr_count=1. Repeat for each of the 7 bit positions of 7'h00 -> out_data=0 and syndrome = position+1 each time.
- Backpressure/overflow: out_ready=0, send 7'h55 then 7'h00 -> first word held stable, overflow pulses once, drop_count=1. Raise out_ready -> 4'hB consumed, out_valid drops.
- Early start of frame: send 3 bits, then rx_sof with a new full 7'h55 -> framing_err pulses once, out_data=4'hB, no spurious output word.
- Gapped input and reset: 7'h55 with rx_bit_valid toggling every other cycle -> correct output. Assert rst after 4 bits -> all outputs 0 and the next clean word decodes normally. Force corr_count near saturation (CNT_W=2, 5 corrected words) -> corr_count holds at 3.
